down_counter: RTL and testbench

Loadable down-counting timer: software or control logic loads a count `N`, and the block decrements once per enabled cycle until it expires. It is the countdown counterpart of the team's up-counter. The up-counter accumulates events toward a terminal count; this block consumes a preset budget of events and reports expiry. It sits beside control FSMs as a timeout, delay or event-budget source, with optional periodic auto-reload.

---
 rtl/down_counter_pkg.sv | 19 +
 rtl/down_counter.sv | 94 +++++++++
 tb/tb_down_counter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/down_counter_pkg.sv
// ============================================================================
//  Module   : down_counter_pkg
//  Brief    : Shared state encoding and default width for down_counter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package down_counter_pkg;

    localparam int unsigned c_DEFAULT_BITS = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage : down_counter_pkg

`default_nettype wire

// File: rtl/down_counter.sv
// ============================================================================
//  Module   : down_counter
//  Brief    : Loadable down-counting timer with expiry pulse; optional periodic
//             auto-reload enabled by defining DOWN_COUNTER_AUTO_RELOAD_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module down_counter
    import down_counter_pkg::*;
#(
    parameter int BITS = c_DEFAULT_BITS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ld,
    input  logic [BITS-1:0] din,
    input  logic            cnt,
    input  logic            clr,
    output logic [BITS-1:0] val,
    output logic            tc,
    output logic            busy,
    output logic            done
);

    localparam logic [BITS-1:0] c_ZERO = '0;
    localparam logic [BITS-1:0] c_ONE  = {{(BITS-1){1'b0}}, 1'b1};

    state_e          state_q, state_d;
    logic [BITS-1:0] val_q, val_d;
    logic            done_q, done_d;
    logic            w_expire;

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    logic [BITS-1:0] reload_q, reload_d;
`endif

    // Unregistered so a neighbouring stage can use it as a same-cycle carry.
    assign w_expire = (state_q == RUN) && cnt && (val_q == c_ONE);
    assign tc       = w_expire;
    assign val      = val_q;
    assign busy     = (state_q == RUN);
    assign done     = done_q;

    always_comb begin
        state_d  = state_q;
        val_d    = val_q;
        done_d   = 1'b0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
        reload_d = reload_q;
`endif
        if (clr) begin
            state_d = IDLE;
            val_d   = c_ZERO;
        end else if (ld) begin
            val_d   = din;
            state_d = (din != c_ZERO) ? RUN : IDLE;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
            reload_d = din;
`endif
        end else if (w_expire) begin
            done_d = 1'b1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
            val_d  = reload_q;
`else
            val_d   = c_ZERO;
            state_d = IDLE;
`endif
        end else if ((state_q == RUN) && cnt) begin
            val_d = val_q - c_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            val_q    <= c_ZERO;
            done_q   <= 1'b0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
            reload_q <= c_ZERO;
`endif
        end else begin
            state_q  <= state_d;
            val_q    <= val_d;
            done_q   <= done_d;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
            reload_q <= reload_d;
`endif
        end
    end

endmodule : down_counter

`default_nettype wire

// File: tb/tb_down_counter.sv
// ============================================================================
//  Module   : tb_down_counter
//  Brief    : Self-checking bench for down_counter against a behavioural model;
//             honours DOWN_COUNTER_AUTO_RELOAD_EN when defined.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_down_counter;

    localparam int BITS = 8;

    logic            clk = 1'b0;
    logic            rst, ld, cnt, clr;
    logic [BITS-1:0] din;
    logic [BITS-1:0] val;
    logic            tc, busy, done;

    int checks = 0;
    int errors = 0;

    down_counter #(.BITS(BITS)) dut (
        .clk  (clk),
        .rst  (rst),
        .ld   (ld),
        .din  (din),
        .cnt  (cnt),
        .clr  (clr),
        .val  (val),
        .tc   (tc),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    // Reference: remaining budget, stored reload, running flag, expiry pulse.
    int unsigned m_val, m_reload;
    bit          m_run, m_done, m_valid;
    initial begin
        m_val = 0; m_reload = 0; m_run = 0; m_done = 0; m_valid = 0;
    end

    always @(posedge clk) begin
        if (rst) begin
            m_val <= 0; m_reload <= 0; m_run <= 0; m_done <= 0; m_valid <= 1;
        end else if (clr) begin
            m_val <= 0; m_run <= 0; m_done <= 0;
        end else if (ld) begin
            m_val <= din; m_reload <= din; m_run <= (din != 0); m_done <= 0;
        end else if (m_run && cnt && m_val == 1) begin
            m_done <= 1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
            m_val  <= m_reload;
`else
            m_val  <= 0;
            m_run  <= 0;
`endif
        end else begin
            if (m_run && cnt) m_val <= m_val - 1;
            m_done <= 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("val",  32'(val),  32'(m_val));
            chk("busy", 32'(busy), 32'(m_run));
            chk("done", 32'(done), 32'(m_done));
            chk("tc",   32'(tc),   32'((m_run && cnt && m_val == 1) ? 1 : 0));
        end
    end

    // Apply inputs just after an edge, then advance to just after the next one.
    task automatic cyc(input bit r, input bit l, input logic [BITS-1:0] d,
                       input bit c, input bit k);
        rst = r; ld = l; din = d; cnt = c; clr = k;
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        int dones;
        logic [BITS-1:0] exp_pause [7];
        bit pat [7];
        rst = 1; ld = 1; din = 8'h5a; cnt = 1; clr = 0;

        // Reset held two cycles with ld/cnt active.
        cyc(1, 1, 8'h5a, 1, 0);
        cyc(1, 1, 8'h5a, 1, 0);
        chk("rst_val",  32'(val),  0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_tc",   32'(tc),   0);
        cyc(0, 0, 0, 1, 0);
        chk("idle_val", 32'(val), 0);

        // Full range load.
        cyc(0, 1, 8'hff, 0, 0);
        chk("ld_busy", 32'(busy), 1);
        chk("ld_val",  32'(val),  32'hff);
        dones = 0;
        for (int i = 0; i < 255; i++) begin
            cyc(0, 0, 0, 1, 0);
            if (done) dones++;
        end
        chk("full_done", 32'(done), 1);
        chk("full_dones", 32'(dones), 1);
`ifndef DOWN_COUNTER_AUTO_RELOAD_EN
        chk("full_val",  32'(val),  0);
        chk("full_busy", 32'(busy), 0);
`endif
        cyc(0, 0, 0, 0, 0);
        chk("done_pulse", 32'(done), 0);

        // Pause pattern.
        pat = '{1, 0, 0, 1, 1, 1, 1};
        exp_pause = '{8'h04, 8'h04, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
        cyc(0, 1, 8'h05, 0, 0);
        dones = 0;
        for (int i = 0; i < 7; i++) begin
            cyc(0, 0, 0, pat[i], 0);
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
            if (i < 6) chk("pause_val", 32'(val), 32'(exp_pause[i]));
`else
            chk("pause_val", 32'(val), 32'(exp_pause[i]));
`endif
            if (done) dones++;
        end
        chk("pause_done_last", 32'(done), 1);
        chk("pause_dones", 32'(dones), 1);

        // Restart then abort.
        cyc(0, 1, 8'h10, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0);
        cyc(0, 1, 8'h03, 1, 0);
        chk("restart_val",  32'(val),  3);
        chk("restart_done", 32'(done), 0);
        cyc(0, 0, 0, 1, 1);
        chk("clr_val",  32'(val),  0);
        chk("clr_busy", 32'(busy), 0);
        chk("clr_done", 32'(done), 0);

        // Zero load while running.
        cyc(0, 1, 8'h07, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 1, 8'h00, 1, 0);
        chk("ld0_val",  32'(val),  0);
        chk("ld0_busy", 32'(busy), 0);
        chk("ld0_done", 32'(done), 0);

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
        cyc(0, 1, 8'h04, 0, 0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(0, 0, 0, 1, 0);
            if (done) dones++;
        end
        chk("ar_dones", 32'(dones), 3);
        chk("ar_val",   32'(val),   4);
`endif

        // Randomized traffic, biased toward short counts so expiries are frequent.
        for (int i = 0; i < 4000; i++) begin
            bit r, l, c, k;
            logic [BITS-1:0] d;
            r = ($urandom_range(0, 255) == 0);
            k = ($urandom_range(0, 47) == 0);
            l = ($urandom_range(0, 11) == 0);
            c = ($urandom_range(0, 3) != 0);
            d = ($urandom_range(0, 7) == 0) ? BITS'($urandom) : BITS'($urandom_range(0, 6));
            cyc(r, l, d, c, k);
        end

        cyc(0, 0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_down_counter

`default_nettype wire
